// File: rtl/sal_sched_rr.sv
// Multi-bank DRAM command scheduler: class priority plus shared round-robin bank
// selection, inter-bank timing down-counters and a registered DFI-side command.
module sal_sched_rr #(
    parameter int BK_CNT   = 4,
    parameter int BK_IDX_W = (BK_CNT > 1) ? $clog2(BK_CNT) : 1,
    parameter int T_CCD    = 2,
    parameter int T_RRD    = 2,
    parameter int T_WTR    = 4,
    parameter int T_RTW    = 3,
    parameter int CNT_W    = 4,
    parameter int RD_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BK_CNT-1:0]   pre_req,
    input  logic [BK_CNT-1:0]   rd_req,
    input  logic [BK_CNT-1:0]   wr_req,
    input  logic [BK_CNT-1:0]   act_req,
    input  logic [BK_CNT-1:0]   ref_req,
    output logic [BK_CNT-1:0]   pre_gnt,
    output logic [BK_CNT-1:0]   rd_gnt,
    output logic [BK_CNT-1:0]   wr_gnt,
    output logic [BK_CNT-1:0]   act_gnt,
    output logic [BK_CNT-1:0]   ref_gnt,
    output logic                cmd_valid,
    output logic [2:0]          cmd_type,
    output logic [BK_IDX_W-1:0] cmd_bank
);

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam bit               RD_HI    = (RD_FIRST != 0);

    // T of 0 or 1 imposes no spacing, so the counter is simply left at zero.
    function automatic logic [CNT_W-1:0] load_val(input int t);
        if (t > 1) begin
            return CNT_W'(t - 1);
        end else begin
            return CNT_ZERO;
        end
    endfunction

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
        if (c != CNT_ZERO) begin
            return c - CNT_ONE;
        end else begin
            return CNT_ZERO;
        end
    endfunction

    // Returns {found, index} of the first set bit at or after ptr, wrapping.
    function automatic logic [BK_IDX_W:0] rr_pick(input logic [BK_CNT-1:0]   req,
                                                  input logic [BK_IDX_W-1:0] ptr);
        logic                found;
        logic [BK_IDX_W-1:0] sel;
        logic [BK_IDX_W-1:0] cand;
        found = 1'b0;
        sel   = {BK_IDX_W{1'b0}};
        for (int i = 0; i < BK_CNT; i++) begin
            cand = BK_IDX_W'((int'(ptr) + i) % BK_CNT);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end else begin
                found = found;
            end
        end
        return {found, sel};
    endfunction

    logic [BK_IDX_W-1:0] rr_ptr_r;
    logic [CNT_W-1:0]    ccd_cnt_r;
    logic [CNT_W-1:0]    rrd_cnt_r;
    logic [CNT_W-1:0]    wtr_cnt_r;
    logic [CNT_W-1:0]    rtw_cnt_r;

    logic                rd_ok_s;
    logic                wr_ok_s;
    logic                act_ok_s;
    logic                hi_ok_s;
    logic                lo_ok_s;
    cmd_e                hi_cmd_s;
    cmd_e                lo_cmd_s;
    logic [BK_CNT-1:0]   hi_req_s;
    logic [BK_CNT-1:0]   lo_req_s;

    cmd_e                gnt_cmd_s;
    logic [BK_CNT-1:0]   sel_req_s;
    logic [BK_IDX_W:0]   pick_s;
    logic                gnt_valid_s;
    logic [BK_IDX_W-1:0] gnt_bank_s;
    logic [BK_CNT-1:0]   onehot_s;
    logic [BK_IDX_W-1:0] next_ptr_s;

    assign rd_ok_s  = (|rd_req)  && (ccd_cnt_r == CNT_ZERO) && (wtr_cnt_r == CNT_ZERO);
    assign wr_ok_s  = (|wr_req)  && (ccd_cnt_r == CNT_ZERO) && (rtw_cnt_r == CNT_ZERO);
    assign act_ok_s = (|act_req) && (rrd_cnt_r == CNT_ZERO);

    assign hi_ok_s  = RD_HI ? rd_ok_s : wr_ok_s;
    assign lo_ok_s  = RD_HI ? wr_ok_s : rd_ok_s;
    assign hi_cmd_s = RD_HI ? CMD_RD  : CMD_WR;
    assign lo_cmd_s = RD_HI ? CMD_WR  : CMD_RD;
    assign hi_req_s = RD_HI ? rd_req  : wr_req;
    assign lo_req_s = RD_HI ? wr_req  : rd_req;

    // Class arbitration: highest eligible class wins, ineligible classes are skipped.
    always_comb begin
        gnt_cmd_s = CMD_NOP;
        sel_req_s = {BK_CNT{1'b0}};
        if (rst) begin
            gnt_cmd_s = CMD_NOP;
        end else if (|pre_req) begin
            gnt_cmd_s = CMD_PRE;
            sel_req_s = pre_req;
        end else if (hi_ok_s) begin
            gnt_cmd_s = hi_cmd_s;
            sel_req_s = hi_req_s;
        end else if (lo_ok_s) begin
            gnt_cmd_s = lo_cmd_s;
            sel_req_s = lo_req_s;
        end else if (act_ok_s) begin
            gnt_cmd_s = CMD_ACT;
            sel_req_s = act_req;
        end else if (|ref_req) begin
            gnt_cmd_s = CMD_REF;
            sel_req_s = ref_req;
        end else begin
            gnt_cmd_s = CMD_NOP;
        end
    end

    // Bank selection within the winning class and one-hot grant decode.
    always_comb begin
        pick_s      = rr_pick(sel_req_s, rr_ptr_r);
        gnt_bank_s  = pick_s[BK_IDX_W-1:0];
        gnt_valid_s = pick_s[BK_IDX_W] && (gnt_cmd_s != CMD_NOP);
        next_ptr_s  = BK_IDX_W'((int'(gnt_bank_s) + 1) % BK_CNT);
        for (int i = 0; i < BK_CNT; i++) begin
            onehot_s[i] = gnt_valid_s && (BK_IDX_W'(i) == gnt_bank_s);
        end
        pre_gnt = {BK_CNT{1'b0}};
        rd_gnt  = {BK_CNT{1'b0}};
        wr_gnt  = {BK_CNT{1'b0}};
        act_gnt = {BK_CNT{1'b0}};
        ref_gnt = {BK_CNT{1'b0}};
        case (gnt_cmd_s)
            CMD_PRE: pre_gnt = onehot_s;
            CMD_RD:  rd_gnt  = onehot_s;
            CMD_WR:  wr_gnt  = onehot_s;
            CMD_ACT: act_gnt = onehot_s;
            CMD_REF: ref_gnt = onehot_s;
            default: pre_gnt = {BK_CNT{1'b0}};
        endcase
    end

    // Pointer, timing counters and the registered command output.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r  <= {BK_IDX_W{1'b0}};
            ccd_cnt_r <= CNT_ZERO;
            rrd_cnt_r <= CNT_ZERO;
            wtr_cnt_r <= CNT_ZERO;
            rtw_cnt_r <= CNT_ZERO;
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_NOP;
            cmd_bank  <= {BK_IDX_W{1'b0}};
        end else begin
            ccd_cnt_r <= dec_sat(ccd_cnt_r);
            rrd_cnt_r <= dec_sat(rrd_cnt_r);
            wtr_cnt_r <= dec_sat(wtr_cnt_r);
            rtw_cnt_r <= dec_sat(rtw_cnt_r);
            if (gnt_valid_s) begin
                case (gnt_cmd_s)
                    CMD_RD: begin
                        ccd_cnt_r <= load_val(T_CCD);
                        rtw_cnt_r <= load_val(T_RTW);
                    end
                    CMD_WR: begin
                        ccd_cnt_r <= load_val(T_CCD);
                        wtr_cnt_r <= load_val(T_WTR);
                    end
                    CMD_ACT: rrd_cnt_r <= load_val(T_RRD);
                    default: rrd_cnt_r <= dec_sat(rrd_cnt_r);
                endcase
                rr_ptr_r  <= next_ptr_s;
                cmd_valid <= 1'b1;
                cmd_type  <= gnt_cmd_s;
                cmd_bank  <= gnt_bank_s;
            end else begin
                rr_ptr_r  <= rr_ptr_r;
                cmd_valid <= 1'b0;
                cmd_type  <= CMD_NOP;
                cmd_bank  <= cmd_bank;
            end
        end
    end

endmodule

// File: tb/tb_sal_sched_rr.sv
// Directed-vector bench: grants are checked at once, registered commands go
// through a scoreboard queue popped by an independent output monitor.
module tb_sal_sched_rr;

    localparam logic [2:0] C_NONE = 3'd0;
    localparam logic [2:0] C_ACT  = 3'd1;
    localparam logic [2:0] C_RD   = 3'd2;
    localparam logic [2:0] C_WR   = 3'd3;
    localparam logic [2:0] C_PRE  = 3'd4;
    localparam logic [2:0] C_REF  = 3'd5;
    localparam logic [3:0] F      = 4'b1111;
    localparam logic [3:0] Z      = 4'b0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pre_req = 4'b0000;
    logic [3:0] rd_req  = 4'b0000;
    logic [3:0] wr_req  = 4'b0000;
    logic [3:0] act_req = 4'b0000;
    logic [3:0] ref_req = 4'b0000;
    logic [3:0] pre_gnt, rd_gnt, wr_gnt, act_gnt, ref_gnt;
    logic       cmd_valid;
    logic [2:0] cmd_type;
    logic [1:0] cmd_bank;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [5:0] exp_q[$];
    logic [5:0] mon_exp;
    logic [1:0] bank_hold = 2'd0;

    sal_sched_rr dut (
        .clk(clk), .rst(rst),
        .pre_req(pre_req), .rd_req(rd_req), .wr_req(wr_req),
        .act_req(act_req), .ref_req(ref_req),
        .pre_gnt(pre_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
        .act_gnt(act_gnt), .ref_gnt(ref_gnt),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank)
    );

    always #5 clk = ~clk;

    // Registered view: pops the command expected from the previous cycle's grant.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            n_cmp++;
            if ({cmd_valid, cmd_type, cmd_bank} !== mon_exp) begin
                n_bad++;
                $display("FAIL cmd_out: got valid=%0b type=%0d bank=%0d, want valid=%0b type=%0d bank=%0d",
                         cmd_valid, cmd_type, cmd_bank, mon_exp[5], mon_exp[4:2], mon_exp[1:0]);
            end
        end
    end

    task automatic step(input logic r, input logic [3:0] p, input logic [3:0] rd,
                        input logic [3:0] wr, input logic [3:0] ac, input logic [3:0] rf,
                        input logic [2:0] ecls, input logic [1:0] eb, input string tag);
        logic [3:0]  oh;
        logic [19:0] want;
        logic [19:0] got;
        @(negedge clk);
        rst = r; pre_req = p; rd_req = rd; wr_req = wr; act_req = ac; ref_req = rf;
        #1;
        oh   = 4'b0001 << eb;
        want = {(ecls == C_PRE) ? oh : Z, (ecls == C_RD)  ? oh : Z, (ecls == C_WR) ? oh : Z,
                (ecls == C_ACT) ? oh : Z, (ecls == C_REF) ? oh : Z};
        got  = {pre_gnt, rd_gnt, wr_gnt, act_gnt, ref_gnt};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL gnt_%s: got pre/rd/wr/act/ref=%b want %b", tag, got, want);
        end
        if (r) begin
            bank_hold = 2'd0;
            exp_q.push_back({1'b0, C_NONE, 2'd0});
        end else if (ecls != C_NONE) begin
            bank_hold = eb;
            exp_q.push_back({1'b1, ecls, eb});
        end else begin
            exp_q.push_back({1'b0, C_NONE, bank_hold});
        end
    endtask

    initial begin
        // Reset with every request asserted, then PRE to bank 0 on release
        for (int i = 0; i < 3; i++) step(1'b1, F, F, F, F, F, C_NONE, 2'd0, "rst");
        step(1'b0, F, F, F, F, F, C_PRE, 2'd0, "rst_rel");
        // Class priority
        step(1'b0, 4'b0010, 4'b0100, Z, 4'b1000, Z, C_PRE, 2'd1, "prio_pre");
        step(1'b0, Z, 4'b0100, Z, 4'b1000, Z, C_RD, 2'd2, "prio_rd");
        step(1'b0, Z, Z, Z, 4'b1000, Z, C_ACT, 2'd3, "prio_act");
        step(1'b0, Z, Z, Z, Z, Z, C_NONE, 2'd0, "idle0");
        // Round-robin reads spaced by tCCD=2
        step(1'b0, Z, F, Z, Z, Z, C_RD,   2'd0, "rr0");
        step(1'b0, Z, F, Z, Z, Z, C_NONE, 2'd0, "rr_ccd");
        step(1'b0, Z, F, Z, Z, Z, C_RD,   2'd1, "rr1");
        step(1'b0, Z, F, Z, Z, Z, C_NONE, 2'd0, "rr_ccd");
        step(1'b0, Z, F, Z, Z, Z, C_RD,   2'd2, "rr2");
        step(1'b0, Z, F, Z, Z, Z, C_NONE, 2'd0, "rr_ccd");
        step(1'b0, Z, F, Z, Z, Z, C_RD,   2'd3, "rr3");
        step(1'b0, Z, F, Z, Z, Z, C_NONE, 2'd0, "rr_ccd");
        step(1'b0, Z, F, Z, Z, Z, C_RD,   2'd0, "rr_wrap");
        step(1'b0, Z, F, Z, Z, Z, C_NONE, 2'd0, "rr_ccd");
        step(1'b0, Z, F, Z, Z, Z, C_RD,   2'd1, "rr1b");
        // Mid-stream reset with rr_ptr=2, rtw pending: WR bank0 right after release
        step(1'b1, Z, F, F, Z, Z, C_NONE, 2'd0, "mid_rst");
        step(1'b0, Z, Z, F, Z, Z, C_WR,   2'd0, "post_rst_wr");
        // tWTR blocks RD for 3 cycles, ACT is not blocked
        step(1'b0, Z, 4'b0010, Z, 4'b0100, Z, C_ACT, 2'd2, "wtr_act");
        step(1'b0, Z, 4'b0010, Z, Z, Z, C_NONE, 2'd0, "wtr_blk2");
        step(1'b0, Z, 4'b0010, Z, Z, Z, C_NONE, 2'd0, "wtr_blk3");
        step(1'b0, Z, 4'b0010, Z, Z, Z, C_RD,   2'd1, "wtr_rd");
        // tRRD spacing of ACTs, REF only when ACT is held off
        step(1'b0, Z, Z, Z, 4'b0011, Z, C_ACT,  2'd0, "rrd0");
        step(1'b0, Z, Z, Z, 4'b0011, Z, C_NONE, 2'd0, "rrd_blk");
        step(1'b0, Z, Z, Z, 4'b0011, Z, C_ACT,  2'd1, "rrd1");
        step(1'b0, Z, Z, Z, 4'b0011, 4'b1010, C_REF, 2'd3, "ref_lo");
        step(1'b0, Z, Z, Z, 4'b0011, 4'b1010, C_ACT, 2'd0, "act_over_ref");
        // RD above WR, then tRTW holds WR off
        step(1'b0, Z, 4'b0100, 4'b0001, Z, Z, C_RD, 2'd2, "rd_first");
        step(1'b0, Z, Z, 4'b0001, Z, Z, C_NONE, 2'd0, "rtw_blk1");
        step(1'b0, Z, Z, 4'b0001, Z, Z, C_NONE, 2'd0, "rtw_blk2");
        step(1'b0, Z, Z, 4'b0001, Z, Z, C_WR,   2'd0, "rtw_wr");
        step(1'b0, Z, Z, Z, Z, Z, C_NONE, 2'd0, "idle_end");
        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sal_sched_rr.md
Name: sal_sched_rr

Overview:
- Multi-bank command scheduler between the per-bank FSMs and the DFI command path.
- Each cycle it selects at most one bank command (PRE/RD/WR/ACT/REF) and grants it combinationally.
- Selection uses a fixed class priority plus round-robin fairness across banks.
- It enforces inter-bank timing (tCCD, tRRD, tWTR, tRTW) with down-counters and registers the granted command onto a one-cycle-latency DFI-side command output.

Parameters:
- BK_CNT, 4: number of banks arbitrated (>=1).
- BK_IDX_W, $clog2(BK_CNT) (min 1): bank index width.
- T_CCD, 2: min cycles between any two column commands (RD/WR).
- T_RRD, 2: min cycles between two ACTs.
- T_WTR, 4: min cycles from WR grant to next RD grant.
- T_RTW, 3: min cycles from RD grant to next WR grant.
- CNT_W, 4: timing-counter width; every T_* must be < 2**CNT_W.
- RD_FIRST, 1: 1 = RD class above WR; 0 = WR class above RD.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- pre_req, input, BK_CNT: per-bank precharge request.
- rd_req, input, BK_CNT: per-bank read request.
- wr_req, input, BK_CNT: per-bank write request.
- act_req, input, BK_CNT: per-bank activate request.
- ref_req, input, BK_CNT: per-bank refresh request.
- pre_gnt, output, BK_CNT: precharge grant, combinational.
- rd_gnt, output, BK_CNT: read grant, combinational.
- wr_gnt, output, BK_CNT: write grant, combinational.
- act_gnt, output, BK_CNT: activate grant, combinational.
- ref_gnt, output, BK_CNT: refresh grant, combinational.
- cmd_valid, output, 1: registered command valid.
- cmd_type, output, 3: registered command type. 0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE, 5=REF.
- cmd_bank, output, BK_IDX_W: registered bank index of the command.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst.
- While rst is high:
  - all *_gnt = 0;
  - cmd_valid = 0, cmd_type = 0, cmd_bank = 0;
  - RR pointer = 0;
  - all timing counters = 0.
- Grants are combinational from the current req inputs and registered state. At most one bit across all five grant vectors is high per cycle.
- Class priority, highest first: PRE > (RD,WR ordered by RD_FIRST) > ACT > REF.
- A class is eligible when its request vector is non-zero and its timing counters are zero:
  - RD: ccd_cnt==0 and wtr_cnt==0.
  - WR: ccd_cnt==0 and rtw_cnt==0.
  - ACT: rrd_cnt==0.
  - PRE, REF: always eligible.
- The highest eligible class wins. An ineligible higher class does not block a lower eligible class.
- Within the winning class, the bank is chosen by round-robin: the first requesting bank at index >= rr_ptr, wrapping modulo BK_CNT.
- On any grant, rr_ptr <= (granted bank + 1) mod BK_CNT. With no grant, rr_ptr holds. The pointer is shared by all classes.
- Counter updates at the clock edge after a grant:
  - RD: ccd_cnt <= T_CCD-1, rtw_cnt <= T_RTW-1.
  - WR: ccd_cnt <= T_CCD-1, wtr_cnt <= T_WTR-1.
  - ACT: rrd_cnt <= T_RRD-1.
  - All other counters decrement, saturating at 0.
  - A T_* of 0 or 1 means no restriction.
- Command output latency is 1 cycle:
  - cmd_valid/cmd_type/cmd_bank register the grant of the previous cycle.
  - With no grant: cmd_valid=0, cmd_type=0; cmd_bank holds its previous value.
- Requests are level-sensitive. A request not granted stays pending with no state kept; the bank FSM holds it until granted.
- A bank may assert several request types at once. Only the class arbitration decides; there are no per-bank checks.
- BK_CNT=1 degenerates to a pure priority/timing filter with rr_ptr fixed at 0.
- rst asserted mid-stream: counters clear and rr_ptr returns to 0 on the same edge. The grants are forced to 0 while rst is high and are not registered.

Test Plan:
1. Reset: rst=1 with all req bits high for 3 cycles -> all gnt=0, cmd_valid=0. Release rst -> first cycle grants pre_gnt[0]; next cycle cmd_type=4, cmd_bank=0.
2. Priority (BK_CNT=4): pre_req=0010, rd_req=0100, act_req=1000 -> pre_gnt=0010 only. Drop pre_req -> rd_gnt=0100. Drop rd_req -> act_gnt=1000.
3. Round-robin: rd_req=1111 held, T_CCD=1 -> rd_gnt sequence 0001, 0010, 0100, 1000, 0001. cmd_bank sequence lags by one cycle.
4. tCCD/tWTR with T_CCD=2, T_WTR=4:
   - WR to bank0 at cycle 0, then rd_req=0010 held -> rd_gnt first at cycle 4; cycles 1-3 show no grant.
   - With act_req=0100 also held -> act_gnt at cycle 1 (lower class not blocked).
5. tRRD with T_RRD=2: act_req=0011 held -> act_gnt at cycles 0 and 2 only, to banks 0 then 1. cmd_valid=0 at cycles 2 and 4 (registered view).
6. Mid-stream reset: rd_req=1111 running with rr_ptr=2 and rtw_cnt=2; assert rst for 1 cycle -> grants 0 that cycle. After release, the first grant is bank0 and wr_req is granted immediately (rtw_cnt cleared).
